sha2_ctrl: RTL and testbench
============================

SHA2_CTRL -- requirements
Module: sha2_ctrl

Interface
REQ-001 Parameters: WDOG_MAX, default 7'd80, maximum RUN cycles allowed before core_done is seen; IN_W, default 32, input word width (fixed at 32).
REQ-002 Ports: clk  in  1  single rising-edge clock for all state.
REQ-003 Ports: reset  in  1  synchronous, active-low reset.
REQ-004 Ports: in_valid  in  1  input word valid.
REQ-005 Ports: in_ready  out  1  controller can accept a word.
REQ-006 Ports: in_data  in  32  message word; first word accepted maps to core_message[511:480], the 16th to [31:0].
REQ-007 Ports: out_valid  out  1  digest/result valid.
REQ-008 Ports: out_ready  in  1  consumer accepts result.
REQ-009 Ports: out_hash  out  256  captured digest.
REQ-010 Ports: out_err  out  1  watchdog expired; out_hash is 0 when set.
REQ-011 Ports: busy  out  1  high in SETTLE and RUN.
REQ-012 Ports: core_reset  out  1  active-high reset to the hash core, registered.
REQ-013 Ports: core_message  out  512  block buffer, driven directly from the buffer register.
REQ-014 Ports: core_k  out  32  round constant, combinational K256[core_t].
REQ-015 Ports: core_t  in  6  round index from the core.
REQ-016 Ports: core_done  in  1  core done flag.
REQ-017 Ports: core_hash  in  256  core state {A..H}.

Function
REQ-018 The FSM shall have states LOAD(2'd0), SETTLE(2'd1), RUN(2'd2) and OUT(2'd3).
REQ-019 LOAD: in_ready=1; each in_valid&&in_ready cycle writes in_data to word slot wcnt (4-bit) and increments wcnt.
REQ-020 When wcnt=15 and a word is accepted, the FSM shall go to SETTLE, and wcnt shall wrap to 0.
REQ-021 SETTLE shall last exactly 1 cycle, with core_reset still 1, then go to RUN.
REQ-022 On entry to RUN, core_reset shall be 0 and wdog shall be cleared to 0.
REQ-023 In RUN, core_reset shall be 0 and wdog shall increment by 1 each cycle.
REQ-024 core_reset shall be 1 in every state other than RUN, including the cycle that OUT is entered.
REQ-025 RUN, rising edge of core_done (core_done=1 and its registered previous value=0): out_hash<=core_hash, out_err<=0, go to OUT.
REQ-026 The core_done edge detector register shall be cleared on entry to RUN, so a core_done already high from a previous block is not counted.
REQ-027 RUN, wdog=WDOG_MAX with no core_done edge: out_hash<=0, out_err<=1, go to OUT.
REQ-028 If the core_done edge and wdog=WDOG_MAX occur in the same cycle, the core_done edge shall win.
REQ-029 OUT: out_valid=1, and out_hash/out_err shall be held stable until out_valid&&out_ready.
REQ-030 On out_valid&&out_ready the FSM shall go to LOAD, and the buffer shall be cleared to 0 on the same edge.
REQ-031 in_ready shall be 0 in SETTLE, RUN and OUT; in_valid in those states shall be ignored and the data dropped.
REQ-032 core_message shall change only in LOAD (or on reset/clear), so it is stable whenever core_reset is 1 and during RUN.
REQ-033 core_k: a 64-entry ROM holding the FIPS 180-4 SHA-256 K constants, with K[0]=32'h428a2f98 and K[63]=32'hc67178f2, indexed by core_t with no register stage.
REQ-034 busy=1 exactly in SETTLE and RUN.

Reset
REQ-035 While reset=0 at a clk edge: state=LOAD, wcnt=0, wdog=0, buffer=0, out_hash=0, out_err=0, out_valid=0, core_reset=1, done-edge register=0.
REQ-036 A reset applied mid-LOAD, mid-RUN or in OUT shall discard the partial block or pending result without producing any out_valid pulse.
REQ-037 in_ready shall be 1 on the first cycle after reset is released.

Verification
REQ-038 The bench shall load the 16 words 61626380, 00000000 x14, 00000018, then connect the real core -> out_valid with out_hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad and out_err=0.
REQ-039 The bench shall drive in_valid with a gap every other cycle -> exactly 16 accepted words, the SETTLE cycle seen, and core_reset falling 2 cycles after the 16th accepted word.
REQ-040 The bench shall use a stub core that keeps core_done=0 -> out_err=1 and out_hash=0 after WDOG_MAX+1 RUN cycles, then LOAD after the out_ready handshake.
REQ-041 The bench shall use a stub core that asserts core_done and hold out_ready=0 for 10 cycles -> out_hash constant throughout and in_ready=0; after out_ready=1 for one cycle -> in_ready=1.
REQ-042 The bench shall assert reset=0 at RUN cycle 20 -> core_reset=1 and out_valid=0 on the next cycle, and a following full block still hashes correctly.
REQ-043 The bench shall sweep core_t over 0..63 -> core_k equals K256[core_t] in the same cycle.

Source files
------------

// File: rtl/sha2_ctrl_if.sv
// sha2_ctrl_if: message-word input and digest output handshakes of the SHA-256 controller
interface sha2_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_hash;
  logic         out_err;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_hash, out_err);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_hash, out_err);
endinterface

// File: rtl/sha2_ctrl.sv
// sha2_ctrl: buffers a 16-word block, runs the hash core under a watchdog and hands back the digest
module sha2_ctrl #(
  parameter logic [6:0] WDOG_MAX = 7'd80,
  parameter int         IN_W     = 32
) (
  input  logic           clk,
  input  logic           reset,
  sha2_ctrl_if.slave     bus,
  output logic           busy,
  output logic           core_reset,
  output logic [511:0]   core_message,
  output logic [31:0]    core_k,
  input  logic [5:0]     core_t,
  input  logic           core_done,
  input  logic [255:0]   core_hash
);
  typedef enum logic [1:0] {LOAD = 2'd0, SETTLE = 2'd1, RUN = 2'd2, OUT = 2'd3} state_t;

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t         state_q, state_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic [6:0]     wdog_q, wdog_d;
  logic [511:0]   blk_q, blk_d;
  logic [255:0]   hash_q, hash_d;
  logic           err_q, err_d;
  logic           core_reset_q, core_reset_d;
  logic           done_q, done_d;

  assign core_k        = K256[core_t];
  assign core_reset    = core_reset_q;
  assign core_message  = blk_q;
  assign busy          = (state_q == SETTLE) || (state_q == RUN);
  assign bus.in_ready  = state_q == LOAD;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_hash  = hash_q;
  assign bus.out_err   = err_q;

  // next state: word capture, watchdog/done race (done wins), result hold until handshake
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    blk_d   = blk_q;
    hash_d  = hash_q;
    err_d   = err_q;
    wdog_d  = (state_q == RUN) ? wdog_q + 7'd1 : 7'd0;
    done_d  = (state_q == RUN) ? core_done : 1'b0;
    case (state_q)
      LOAD: if (bus.in_valid) begin
        blk_d[{~wcnt_q, 5'd0} +: IN_W] = bus.in_data;
        wcnt_d = wcnt_q + 4'd1;
        state_d = (wcnt_q == 4'd15) ? SETTLE : LOAD;
      end
      SETTLE: state_d = RUN;
      RUN: if (core_done && !done_q) begin
        hash_d  = core_hash;
        err_d   = 1'b0;
        state_d = OUT;
      end else if (wdog_q == WDOG_MAX) begin
        hash_d  = '0;
        err_d   = 1'b1;
        state_d = OUT;
      end
      OUT: if (bus.out_ready) begin
        blk_d   = '0;
        state_d = LOAD;
      end
    endcase
    core_reset_d = state_d != RUN;
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= LOAD;
      wcnt_q       <= '0;
      wdog_q       <= '0;
      blk_q        <= '0;
      hash_q       <= '0;
      err_q        <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      wdog_q       <= wdog_d;
      blk_q        <= blk_d;
      hash_q       <= hash_d;
      err_q        <= err_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
    end
  end
endmodule

// File: tb/tb_sha2_ctrl.sv
// tb_sha2_ctrl: scoreboard bench with a behavioural SHA-256 core and stub cores
module tb_sha2_ctrl;
  localparam logic [255:0] ABC    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] STUB_H = 256'h0123456789abcdeffedcba9876543210_5a5aa5a5c3c33c3c_0f0ff0f011112222;
  localparam int WMAX = 80;

  typedef struct { logic [255:0] h; logic e; } exp_t;

  logic clk = 0, reset = 0;
  logic busy, core_reset, core_done;
  logic [511:0] core_message;
  logic [31:0] core_k;
  logic [5:0] core_t, sweep_t;
  logic [255:0] core_hash;
  logic sweep_en = 0;
  int mode = 0;
  int checks = 0, fails = 0;
  int run_cnt = 0, acc_cnt = 0;
  exp_t q[$];
  logic [31:0] blk_w [16];
  logic [31:0] kref [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] h0 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  sha2_ctrl_if bus();

  sha2_ctrl #(.WDOG_MAX(7'd80), .IN_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .core_reset(core_reset),
    .core_message(core_message), .core_k(core_k), .core_t(core_t),
    .core_done(core_done), .core_hash(core_hash)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // behavioural SHA-256 core: one round per cycle using the controller's K output
  logic [31:0] s [8];
  logic [31:0] w [16];
  logic [6:0] rcnt;
  logic cdone;
  logic [255:0] digest;
  logic [7:0] scnt;

  assign core_t    = sweep_en ? sweep_t : rcnt[5:0];
  assign core_done = (mode == 0) ? cdone : (mode == 2) ? (scnt >= 8'd5) : 1'b0;
  assign core_hash = (mode == 0) ? digest : (mode == 1) ? {8{32'hffffffff}} : STUB_H;

  always @(posedge clk) begin : core_model
    logic [31:0] t1, t2, nw;
    if (core_reset) begin
      rcnt <= 0;
      cdone <= 0;
      scnt <= 0;
      for (int i = 0; i < 8; i++) s[i] <= h0[i];
      for (int i = 0; i < 16; i++) w[i] <= core_message[511 - 32*i -: 32];
    end else begin
      if (scnt != 8'hff) scnt <= scnt + 1;
      if (rcnt < 64) begin
        t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + core_k + w[0];
        t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        nw = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9] + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
        s[7] <= s[6]; s[6] <= s[5]; s[5] <= s[4]; s[4] <= s[3] + t1;
        s[3] <= s[2]; s[2] <= s[1]; s[1] <= s[0]; s[0] <= t1 + t2;
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= nw;
        rcnt <= rcnt + 1;
      end else if (!cdone) begin
        digest <= {s[0]+h0[0], s[1]+h0[1], s[2]+h0[2], s[3]+h0[3], s[4]+h0[4], s[5]+h0[5], s[6]+h0[6], s[7]+h0[7]};
        cdone <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every cycle a result is presented must match the head expectation
  always @(negedge clk) begin
    if (reset) begin
      if (!core_reset) run_cnt++;
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out: got out_valid=1 expected no pending result");
        end else begin
          chk("sb_hash", bus.out_hash, q[0].h);
          chk("sb_err", bus.out_err, q[0].e);
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic send_block(input bit gap);
    for (int k = 0; k < 16; k++) begin
      if (gap) begin
        bus.in_valid = 0;
        bus.in_data = 32'hdeadbeef;
        @(posedge clk); #1;
      end
      bus.in_valid = 1;
      bus.in_data = blk_w[k];
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!bus.out_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      fails++;
      $display("FAIL out_timeout: got out_valid=0 expected 1 within %0d cycles", bound);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, a0;
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.out_ready = 0;
    for (int i = 0; i < 16; i++) blk_w[i] = 0;
    blk_w[0] = 32'h61626380;
    blk_w[15] = 32'h00000018;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_msg", core_message, 0);
    chk("rst_hash", bus.out_hash, 0);
    chk("rst_err", bus.out_err, 0);
    reset = 1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);

    sweep_en = 1;
    for (int i = 0; i < 64; i++) begin
      sweep_t = 6'(i);
      #1;
      chk($sformatf("core_k_%0d", i), core_k, kref[i]);
    end
    sweep_en = 0;
    @(posedge clk); #1;

    // real core, back-to-back words
    q.push_back('{ABC, 1'b0});
    bus.out_ready = 1;
    send_block(0);
    wait_valid(200);
    @(posedge clk); #1;
    chk("a_in_ready", bus.in_ready, 1);
    chk("a_msg_clear", core_message, 0);

    // gapped input, words offered during RUN must be dropped
    a0 = acc_cnt;
    q.push_back('{ABC, 1'b0});
    send_block(1);
    chk("b_settle_busy", busy, 1);
    chk("b_settle_ready", bus.in_ready, 0);
    chk("b_settle_core_reset", core_reset, 1);
    bus.in_valid = 1;
    bus.in_data = 32'hffffffff;
    @(posedge clk); #1;
    chk("b_run_core_reset", core_reset, 0);
    chk("b_run_busy", busy, 1);
    repeat (10) @(posedge clk);
    #1;
    bus.in_valid = 0;
    wait_valid(200);
    chk("b_accepted", acc_cnt - a0, 16);
    @(posedge clk); #1;

    // never-done stub: watchdog expires after WDOG_MAX+1 RUN cycles
    mode = 1;
    bus.out_ready = 0;
    q.push_back('{256'h0, 1'b1});
    r0 = run_cnt;
    send_block(0);
    wait_valid(300);
    chk("c_run_cycles", run_cnt - r0, WMAX + 1);
    chk("c_core_reset_out", core_reset, 1);
    @(posedge clk); #1;
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    chk("c_in_ready", bus.in_ready, 1);

    // done stub with back-pressure: result held, no input accepted
    mode = 2;
    q.push_back('{STUB_H, 1'b0});
    send_block(0);
    wait_valid(100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("d_in_ready_hold", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    chk("d_in_ready", bus.in_ready, 1);

    // reset while a result is pending discards it
    q.push_back('{STUB_H, 1'b0});
    send_block(0);
    wait_valid(100);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    q.delete();
    chk("f_out_valid", bus.out_valid, 0);
    chk("f_hash_clr", bus.out_hash, 0);
    reset = 1;
    @(posedge clk); #1;

    // reset mid-LOAD and mid-RUN, then a full block still hashes
    mode = 0;
    bus.out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1;
      bus.in_data = 32'h11111111 * (k + 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    chk("e_msg_rst", core_message, 0);
    send_block(0);
    r0 = run_cnt;
    for (int n = 0; n < 200 && run_cnt - r0 < 20; n++) @(posedge clk);
    #1;
    reset = 0;
    @(posedge clk); #1;
    chk("e_core_reset", core_reset, 1);
    chk("e_out_valid", bus.out_valid, 0);
    reset = 1;
    @(posedge clk); #1;
    chk("e_in_ready", bus.in_ready, 1);
    q.push_back('{ABC, 1'b0});
    send_block(0);
    wait_valid(200);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
